// File: rtl/dsp_mac_param.sv
// dsp_mac_param: parametrised pipelined signed multiply-accumulate slice.
// Stage 1 (optional input regs) -> pre-adder -> multiplier -> stage 2 (optional
// M regs) -> post-adder with saturation / self-framing accumulator -> P regs.
module dsp_mac_param #(
    parameter int A_WIDTH = 18,
    parameter int B_WIDTH = 18,
    parameter int C_WIDTH = 48,
    parameter int P_WIDTH = 48,
    parameter int INREG   = 1,
    parameter int MREG    = 1,
    parameter int ACC_LEN = 16,
    parameter int SAT_EN  = 1
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       CE,
    input  logic                       in_valid,
    input  logic [A_WIDTH-1:0]         A,
    input  logic [B_WIDTH-1:0]         B,
    input  logic [B_WIDTH-1:0]         D,
    input  logic [C_WIDTH-1:0]         C,
    input  logic                       CARRYIN,
    input  logic [3:0]                 OPMODE,
    input  logic                       acc_clear,
    output logic                       out_valid,
    output logic [P_WIDTH-1:0]         P,
    output logic [A_WIDTH+B_WIDTH:0]   M,
    output logic                       OVF,
    output logic                       OVF_STICKY,
    output logic                       acc_done
);

    localparam int MW    = A_WIDTH + B_WIDTH + 1;
    localparam int SB_W  = C_WIDTH + 7;
    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ACC_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'((ACC_LEN == 1) ? 0 : 1);
    localparam logic [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

    // Sideband bundle travelling with the data: {valid, acc_clear, carryin, opmode, C}
    logic [SB_W-1:0]    w_sb_in;
    logic [A_WIDTH-1:0] w_s1_a;
    logic [B_WIDTH-1:0] w_s1_b;
    logic [B_WIDTH-1:0] w_s1_d;
    logic [SB_W-1:0]    w_s1_sb;
    logic [MW-1:0]      w_s2_m;
    logic [SB_W-1:0]    w_s2_sb;

    assign w_sb_in = {in_valid, acc_clear, CARRYIN, OPMODE, C};

    generate
        if (INREG != 0) begin : g_inreg
            logic [A_WIDTH-1:0] r_a;
            logic [B_WIDTH-1:0] r_b;
            logic [B_WIDTH-1:0] r_d;
            logic [SB_W-1:0]    r_sb;
            // Input register stage, frozen while CE is low
            always_ff @(posedge clk or posedge RST) begin
                if (RST) begin
                    r_a  <= {A_WIDTH{1'b0}};
                    r_b  <= {B_WIDTH{1'b0}};
                    r_d  <= {B_WIDTH{1'b0}};
                    r_sb <= {SB_W{1'b0}};
                end else if (CE) begin
                    r_a  <= A;
                    r_b  <= B;
                    r_d  <= D;
                    r_sb <= w_sb_in;
                end
            end
            assign w_s1_a  = r_a;
            assign w_s1_b  = r_b;
            assign w_s1_d  = r_d;
            assign w_s1_sb = r_sb;
        end else begin : g_in_bypass
            assign w_s1_a  = A;
            assign w_s1_b  = B;
            assign w_s1_d  = D;
            assign w_s1_sb = w_sb_in;
        end
    endgenerate

    // Pre-adder works one bit wider than B/D so D+B and D-B never truncate.
    logic [B_WIDTH:0] w_b_ext;
    logic [B_WIDTH:0] w_d_ext;
    logic [B_WIDTH:0] w_pre;
    logic [MW-1:0]    w_a_mul;
    logic [MW-1:0]    w_pre_mul;
    logic [MW-1:0]    w_mult;

    assign w_b_ext = {w_s1_b[B_WIDTH-1], w_s1_b};
    assign w_d_ext = {w_s1_d[B_WIDTH-1], w_s1_d};

    // Pre-adder operand selection from stage-1 OPMODE[1:0]
    always_comb begin
        w_pre = w_b_ext;
        if (w_s1_sb[C_WIDTH]) begin
            if (w_s1_sb[C_WIDTH+1]) begin
                w_pre = w_d_ext - w_b_ext;
            end else begin
                w_pre = w_d_ext + w_b_ext;
            end
        end else begin
            w_pre = w_b_ext;
        end
    end

    // Both operands sign-extended to the full product width; low MW bits are exact.
    assign w_a_mul   = {{(MW-A_WIDTH){w_s1_a[A_WIDTH-1]}}, w_s1_a};
    assign w_pre_mul = {{(MW-B_WIDTH-1){w_pre[B_WIDTH]}}, w_pre};
    assign w_mult    = $signed(w_a_mul) * $signed(w_pre_mul);

    generate
        if (MREG != 0) begin : g_mreg
            logic [MW-1:0]   r_m;
            logic [SB_W-1:0] r_sb2;
            // Multiplier output register stage, frozen while CE is low
            always_ff @(posedge clk or posedge RST) begin
                if (RST) begin
                    r_m   <= {MW{1'b0}};
                    r_sb2 <= {SB_W{1'b0}};
                end else if (CE) begin
                    r_m   <= w_mult;
                    r_sb2 <= w_s1_sb;
                end
            end
            assign w_s2_m  = r_m;
            assign w_s2_sb = r_sb2;
        end else begin : g_m_bypass
            assign w_s2_m  = w_mult;
            assign w_s2_sb = w_s1_sb;
        end
    endgenerate

    assign M = w_s2_m;

    // P-stage sideband decode
    logic [C_WIDTH-1:0] w_c;
    logic [3:0]         w_op;
    logic               w_cin;
    logic               w_clr;
    logic               w_vld;

    assign w_c   = w_s2_sb[C_WIDTH-1:0];
    assign w_op  = w_s2_sb[C_WIDTH+3:C_WIDTH];
    assign w_cin = w_s2_sb[C_WIDTH+4];
    assign w_clr = w_s2_sb[C_WIDTH+5];
    assign w_vld = w_s2_sb[C_WIDTH+6];

    logic [P_WIDTH-1:0] r_p;
    logic               r_ovf;
    logic               r_sticky;
    logic               r_out_valid;
    logic               r_acc_done;
    logic [CNT_W-1:0]   r_cnt;

    // Post-adder is evaluated one bit wider than P to expose overflow.
    logic [P_WIDTH:0]   w_c_ext;
    logic [P_WIDTH:0]   w_m_ext;
    logic [P_WIDTH:0]   w_mc;
    logic [P_WIDTH:0]   w_z;
    logic [P_WIDTH:0]   w_r;
    logic               w_ovf;
    logic [P_WIDTH-1:0] w_p_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_done;

    assign w_c_ext = {{(P_WIDTH+1-C_WIDTH){w_c[C_WIDTH-1]}}, w_c};
    assign w_m_ext = {{(P_WIDTH+1-MW){w_s2_m[MW-1]}}, w_s2_m};
    assign w_mc    = w_m_ext + {{P_WIDTH{1'b0}}, w_cin};

    // Z operand: C, or the running accumulator (zero at the start of a frame)
    always_comb begin
        w_z = w_c_ext;
        if (w_op[2]) begin
            if (w_clr || (r_cnt == CNT_ZERO)) begin
                w_z = {(P_WIDTH+1){1'b0}};
            end else begin
                w_z = {r_p[P_WIDTH-1], r_p};
            end
        end else begin
            w_z = w_c_ext;
        end
    end

    assign w_r   = w_op[3] ? (w_z - w_mc) : (w_z + w_mc);
    assign w_ovf = w_r[P_WIDTH] ^ w_r[P_WIDTH-1];

    // Saturate or wrap the wide post-adder result into P_WIDTH bits
    always_comb begin
        w_p_next = w_r[P_WIDTH-1:0];
        if (w_ovf && (SAT_EN != 0)) begin
            if (w_r[P_WIDTH]) begin
                w_p_next = P_MIN;
            end else begin
                w_p_next = P_MAX;
            end
        end else begin
            w_p_next = w_r[P_WIDTH-1:0];
        end
    end

    // Frame counter advance; acc_clear on the last slot restarts without a done
    always_comb begin
        w_cnt_next = r_cnt;
        w_done     = 1'b0;
        if (w_op[2]) begin
            if (w_clr) begin
                w_cnt_next = CNT_START;
                w_done     = (ACC_LEN == 1);
            end else if (r_cnt == CNT_LAST) begin
                w_cnt_next = CNT_ZERO;
                w_done     = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CNT_ONE;
                w_done     = 1'b0;
            end
        end else begin
            w_cnt_next = CNT_ZERO;
            w_done     = 1'b0;
        end
    end

    // Result register: updates only on a valid P-stage sample with CE high
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_p         <= {P_WIDTH{1'b0}};
            r_ovf       <= 1'b0;
            r_sticky    <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc_done  <= 1'b0;
            r_cnt       <= CNT_ZERO;
        end else if (CE && w_vld) begin
            r_p         <= w_p_next;
            r_ovf       <= w_ovf;
            r_sticky    <= (w_clr ? 1'b0 : r_sticky) | w_ovf;
            r_out_valid <= 1'b1;
            r_acc_done  <= w_done;
            r_cnt       <= w_cnt_next;
        end else begin
            r_out_valid <= 1'b0;
            r_acc_done  <= 1'b0;
        end
    end

    assign P          = r_p;
    assign OVF        = r_ovf;
    assign OVF_STICKY = r_sticky;
    assign out_valid  = r_out_valid;
    assign acc_done   = r_acc_done;

endmodule

// File: tb/tb_dsp_mac_param.sv
// Scoreboard bench for dsp_mac_param. Four instances share one stimulus stream:
// 0 = defaults, 1 = ACC_LEN 4, 2 = P_WIDTH 40 saturating, 3 = P_WIDTH 40 wrapping.
module tb_dsp_mac_param;

    logic        clk = 1'b0;
    logic        rst, ce, vld, cin, clr;
    logic [17:0] s_a, s_b, s_d;
    logic [47:0] s_c;
    logic [3:0]  s_op;

    logic [47:0] p0, p1;
    logic [39:0] p2, p3;
    logic [36:0] m0, m1, m2, m3;
    logic [3:0]  ov, of, st, dn;

    int checks = 0;
    int errors = 0;
    int ce_edges = 0;

    typedef struct {
        longint p;
        bit     ovf;
        bit     st;
        bit     done;
        int     issue;
    } exp_t;

    exp_t   q [4][$];
    longint mp [4];
    int     mcnt [4];
    bit     mst [4];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ce === 1'b1) ce_edges <= ce_edges + 1;
    end

    dsp_mac_param u_def (
        .clk(clk), .RST(rst), .CE(ce), .in_valid(vld), .A(s_a), .B(s_b), .D(s_d), .C(s_c),
        .CARRYIN(cin), .OPMODE(s_op), .acc_clear(clr), .out_valid(ov[0]), .P(p0), .M(m0),
        .OVF(of[0]), .OVF_STICKY(st[0]), .acc_done(dn[0]));

    dsp_mac_param #(.ACC_LEN(4)) u_acc4 (
        .clk(clk), .RST(rst), .CE(ce), .in_valid(vld), .A(s_a), .B(s_b), .D(s_d), .C(s_c),
        .CARRYIN(cin), .OPMODE(s_op), .acc_clear(clr), .out_valid(ov[1]), .P(p1), .M(m1),
        .OVF(of[1]), .OVF_STICKY(st[1]), .acc_done(dn[1]));

    dsp_mac_param #(.C_WIDTH(40), .P_WIDTH(40), .ACC_LEN(64), .SAT_EN(1)) u_sat (
        .clk(clk), .RST(rst), .CE(ce), .in_valid(vld), .A(s_a), .B(s_b), .D(s_d), .C(s_c[39:0]),
        .CARRYIN(cin), .OPMODE(s_op), .acc_clear(clr), .out_valid(ov[2]), .P(p2), .M(m2),
        .OVF(of[2]), .OVF_STICKY(st[2]), .acc_done(dn[2]));

    dsp_mac_param #(.C_WIDTH(40), .P_WIDTH(40), .ACC_LEN(64), .SAT_EN(0)) u_wrap (
        .clk(clk), .RST(rst), .CE(ce), .in_valid(vld), .A(s_a), .B(s_b), .D(s_d), .C(s_c[39:0]),
        .CARRYIN(cin), .OPMODE(s_op), .acc_clear(clr), .out_valid(ov[3]), .P(p3), .M(m3),
        .OVF(of[3]), .OVF_STICKY(st[3]), .acc_done(dn[3]));

    function automatic int pw_of(input int i);
        return (i < 2) ? 48 : 40;
    endfunction

    function automatic int al_of(input int i);
        return (i == 0) ? 16 : ((i == 1) ? 4 : 64);
    endfunction

    function automatic bit sat_of(input int i);
        return (i != 3);
    endfunction

    task automatic cmp(input int i, input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst%0d actual=%0d required=%0d", name, i, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            mp[i]   = 64'sd0;
            mcnt[i] = 0;
            mst[i]  = 1'b0;
        end
    endtask

    // Reference: arithmetic straight from the operand rules, on 64-bit integers.
    task automatic model_push(input int i);
        longint a, b, d, c, pre, z, r, maxv, minv, pn;
        bit     o, done;
        int     w, al;
        exp_t   e;
        w  = pw_of(i);
        al = al_of(i);
        a  = longint'($signed(s_a));
        b  = longint'($signed(s_b));
        d  = longint'($signed(s_d));
        if (w == 48) c = longint'($signed(s_c));
        else         c = longint'($signed(s_c[39:0]));
        if (s_op[0]) pre = s_op[1] ? (d - b) : (d + b);
        else         pre = b;
        if (s_op[2]) z = (clr || mcnt[i] == 0) ? 64'sd0 : mp[i];
        else         z = c;
        if (s_op[3]) r = z - (a * pre + longint'(cin));
        else         r = z + (a * pre + longint'(cin));
        maxv = (64'sd1 <<< (w - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (w - 1));
        o    = (r > maxv) || (r < minv);
        if (!o)            pn = r;
        else if (sat_of(i)) pn = (r > maxv) ? maxv : minv;
        else               pn = (r <<< (64 - w)) >>> (64 - w);
        if (s_op[2]) begin
            if (clr) begin
                done    = (al == 1);
                mcnt[i] = (al == 1) ? 0 : 1;
            end else begin
                done    = (mcnt[i] == al - 1);
                mcnt[i] = (mcnt[i] + 1) % al;
            end
        end else begin
            done    = 1'b0;
            mcnt[i] = 0;
        end
        mst[i]  = (clr ? 1'b0 : mst[i]) | o;
        mp[i]   = pn;
        e.p     = pn;
        e.ovf   = o;
        e.st    = mst[i];
        e.done  = done;
        e.issue = ce_edges;
        q[i].push_back(e);
    endtask

    task automatic check(input int i, input longint p, input bit o, input bit s, input bit d);
        exp_t e;
        if (q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid inst%0d actual P=%0d required no result", i, p);
        end else begin
            e = q[i].pop_front();
            cmp(i, "P", p, e.p);
            cmp(i, "OVF", longint'(o), longint'(e.ovf));
            cmp(i, "OVF_STICKY", longint'(s), longint'(e.st));
            cmp(i, "acc_done", longint'(d), longint'(e.done));
            // CE edges from the capturing edge to the result edge, both inclusive
            cmp(i, "latency", longint'(ce_edges - e.issue + 1), 64'sd3);
        end
    endtask

    // Monitor: pops the scoreboard whenever an instance presents a result
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ov[0]) check(0, longint'($signed(p0)), of[0], st[0], dn[0]);
            if (ov[1]) check(1, longint'($signed(p1)), of[1], st[1], dn[1]);
            if (ov[2]) check(2, longint'($signed(p2)), of[2], st[2], dn[2]);
            if (ov[3]) check(3, longint'($signed(p3)), of[3], st[3], dn[3]);
        end
    end

    task automatic step(input bit v, input bit c_e, input logic [17:0] a, input logic [17:0] b,
                        input logic [17:0] d, input logic [47:0] c, input logic [3:0] op,
                        input bit ci, input bit cl);
        @(negedge clk);
        vld = v; ce = c_e; s_a = a; s_b = b; s_d = d; s_c = c; s_op = op; cin = ci; clr = cl;
        @(posedge clk);
        #1;
        if (v && c_e) begin
            for (int i = 0; i < 4; i++) model_push(i);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 18'd0, 18'd0, 18'd0, 48'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic drain_check();
        for (int i = 0; i < 4; i++) cmp(i, "pending_results", longint'(q[i].size()), 64'sd0);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; vld = 1'b0; cin = 1'b0; clr = 1'b0;
        s_a = 18'd0; s_b = 18'd0; s_d = 18'd0; s_c = 48'd0; s_op = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        cmp(0, "rst_out_valid", longint'(ov), 64'sd0);
        cmp(0, "rst_P", longint'(p0), 64'sd0);
        cmp(2, "rst_P", longint'(p2), 64'sd0);
        cmp(0, "rst_M", longint'(m0 | m1 | m2 | m3), 64'sd0);
        cmp(0, "rst_OVF", longint'(of | st), 64'sd0);
        cmp(0, "rst_acc_done", longint'(dn), 64'sd0);
        rst = 1'b0;

        // basic multiply: 10 + 3*5 + 1
        step(1'b1, 1'b1, 18'd3, 18'd5, 18'd0, 48'd10, 4'b0000, 1'b1, 1'b0);
        // pre-adder add, subtract, and post-subtract with C
        step(1'b1, 1'b1, 18'd2, 18'd450, 18'd500, 48'd0,    4'b0001, 1'b0, 1'b0);
        step(1'b1, 1'b1, 18'd2, 18'd450, 18'd500, 48'd0,    4'b0011, 1'b0, 1'b0);
        step(1'b1, 1'b1, 18'd2, 18'd450, 18'd500, 48'd1000, 4'b1011, 1'b0, 1'b0);
        // accumulate frame A = 1..5, B = 1
        for (int k = 1; k <= 5; k++)
            step(1'b1, 1'b1, 18'(k), 18'd1, 18'd0, 48'd0, 4'b0100, 1'b0, (k == 1));
        // saturation / wrap: product 2^34 accumulated 33 times
        for (int k = 0; k < 33; k++)
            step(1'b1, 1'b1, 18'h20000, 18'h20000, 18'd0, 48'd0, 4'b0100, 1'b0, (k == 0));
        // CE stall inside a 4-sample burst
        for (int k = 0; k < 6; k++) begin
            if (k == 2 || k == 3)
                step(1'b0, 1'b0, 18'd0, 18'd0, 18'd0, 48'd0, 4'd0, 1'b0, 1'b0);
            else
                step(1'b1, 1'b1, 18'($urandom), 18'($urandom), 18'($urandom),
                     48'({$urandom, $urandom}), 4'b0100, 1'($urandom), 1'b0);
        end
        // randomized traffic with random valid, CE and frame restarts
        for (int k = 0; k < 300; k++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                 18'($urandom), 18'($urandom), 18'($urandom), 48'({$urandom, $urandom}),
                 4'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
        idle(8);
        drain_check();

        // asynchronous reset with two samples in flight
        step(1'b1, 1'b1, 18'd7, 18'd9, 18'd0, 48'd1, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 18'd4, 18'd4, 18'd0, 48'd2, 4'b0000, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        cmp(0, "async_rst_out_valid", longint'(ov), 64'sd0);
        cmp(0, "async_rst_P", longint'(p0), 64'sd0);
        cmp(1, "async_rst_P", longint'(p1), 64'sd0);
        model_reset();
        @(negedge clk);
        vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 18'd6, 18'd7, 18'd0, 48'd5, 4'b0000, 1'b0, 1'b0);
        idle(6);
        drain_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_mac_param.md
Name: dsp_mac_param

Overview:
- Parametrised, pipelined signed multiply-accumulate slice. It is the next-generation arithmetic core for the DSP datapath.
- Datapath: optional pre-adder/subtractor on B/D, then signed multiplier A*PRE, then post-adder.
- Post-adder modes: add C, or run a self-framing accumulator that emits a result every ACC_LEN products.
- Adds generic widths, a selectable pipeline depth, a valid handshake, saturation, and overflow flags.

Parameters:
- A_WIDTH, 18, signed A operand width.
- B_WIDTH, 18, signed B and D operand width.
- C_WIDTH, 48, signed C operand width, sign-extended to P_WIDTH; must be <= P_WIDTH.
- P_WIDTH, 48, result/accumulator width; must be >= A_WIDTH+B_WIDTH+1.
- INREG, 1, input register stage present (0 or 1).
- MREG, 1, multiplier output register present (0 or 1).
- ACC_LEN, 16, products per accumulation frame (>= 1).
- SAT_EN, 1, 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- clk  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset, all state
- CE  in  1  global clock enable; 0 freezes every pipeline register
- in_valid  in  1  A/B/D/C/OPMODE/CARRYIN/acc_clear valid this cycle
- A  in  A_WIDTH  signed multiplicand
- B  in  B_WIDTH  signed pre-adder operand
- D  in  B_WIDTH  signed pre-adder operand
- C  in  C_WIDTH  signed post-adder operand
- CARRYIN  in  1  added to the post-adder LSB
- OPMODE  in  4  [0] pre-adder enable, [1] pre-subtract, [2] accumulate mode, [3] post-subtract
- acc_clear  in  1  this sample starts a new accumulation frame
- out_valid  out  1  P holds a new result (one-cycle pulse)
- P  out  P_WIDTH  signed result, registered
- M  out  A_WIDTH+B_WIDTH+1  multiplier output, after the MREG stage
- OVF  out  1  overflow on the current P result
- OVF_STICKY  out  1  sticky overflow; cleared by RST or by acc_clear reaching the P stage
- acc_done  out  1  pulses with out_valid on the last result of a frame

Behaviour:
- Clock and reset: one clock (clk). RST is asynchronous, active-high.
- Reset values: every register, P, M, OVF, OVF_STICKY, out_valid, acc_done and the frame counter are 0.
- Pipeline control:
  - Sideband signals (valid, OPMODE, CARRYIN, acc_clear, C) travel with their data through the stages.
  - A stage loads only when CE=1.
- Pre-adder (combinational, on stage-1 outputs), result PRE is B_WIDTH+1 bits, signed:
  - OPMODE[0]=0: PRE = B.
  - OPMODE[0]=1, OPMODE[1]=0: PRE = D+B.
  - OPMODE[0]=1, OPMODE[1]=1: PRE = D-B.
  - No truncation.
- Multiplier: M = A*PRE, full precision, signed.
- Post-adder:
  - Z = (OPMODE[2] ? accumulator operand : sext(C)).
  - OPMODE[3]=0: R = Z + M + CARRYIN. OPMODE[3]=1: R = Z - (M + CARRYIN).
  - R is evaluated at P_WIDTH+1 bits.
- Overflow:
  - OVF=1 when R does not fit in P_WIDTH bits.
  - SAT_EN=1: P clamps to +max or -min. SAT_EN=0: P takes the low P_WIDTH bits.
  - OVF_STICKY ORs in OVF.
- Latency: a sample with in_valid=1 at CE edge k gives out_valid=1 at edge k+INREG+MREG+1 (3 at defaults), counting CE=1 edges only.
- P, OVF and the counter update only on a valid P-stage sample with CE=1; otherwise they hold.
- out_valid and acc_done are pulses: they are 0 on any edge without a new result, including CE=0 edges. A result is never reported twice.
- Accumulate mode (OPMODE[2]=1 at P stage), frame counter cnt in 0..ACC_LEN-1:
  - Operand is 0 if acc_clear or cnt==0; otherwise it is the current P.
  - Next cnt: acc_clear -> 1 (or 0 if ACC_LEN=1); otherwise cnt+1. cnt wraps to 0 on reaching ACC_LEN.
  - acc_done=1 on the result that completes the frame.
  - With ACC_LEN=1, every result is standalone and has acc_done=1.
- Non-accumulate valid sample: cnt forced to 0, acc_done=0.
- Simultaneous events: acc_clear on the frame's last slot restarts the frame. No acc_done is raised for the truncated frame.
- Reset mid-operation: in-flight samples are discarded. The first post-reset result appears a full latency after its input.

Test Plan:
- Basic multiply: defaults, OPMODE=0000, A=3, B=5, C=10, CARRYIN=1, one valid -> out_valid at edge 3 with P=26, OVF=0.
- Pre-adder: OPMODE=0001, A=2, B=450, D=500, C=0 -> P=1900. With OPMODE=0011 -> P=100. With OPMODE=1011 and C=1000 -> P=900.
- Accumulate frames: ACC_LEN=4, OPMODE=0100, B=1, A=1,2,3,4,5 back-to-back -> P=1,3,6,10 with acc_done only on 10; fifth result P=5, cnt restarts.
- Saturation: P_WIDTH=40, ACC_LEN=64, A=B=-131072 (product 2^34), 32 valid samples:
  - Result 31 gives P=31*2^34.
  - Result 32 gives P=2^39-1, OVF=1, OVF_STICKY stays 1.
  - With SAT_EN=0, result 32 gives P=-2^39.
- CE stall: CE=0 for 2 cycles during a 4-sample burst -> results delayed by exactly 2 cycles, same values, no duplicate out_valid.
- Reset mid-stream: assert RST asynchronously between edges with 2 samples in flight -> P=0, out_valid=0 immediately. No stale results after release; a new sample returns after 3 edges.
